// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type, S-box, rcon and round transform functions
package aes_pkg;
  localparam int NB_BYTES = 16;
  localparam int AES128_NR = 10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;
  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? RCON_TBL[8*(10-int'(i)) +: 8] : 8'h00;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < NB_BYTES; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction
  // byte i sits at [127-8i -: 8]; row r of column c is byte r+4c
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key expansion step (RotWord, SubWord, rcon, word chaining)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);
  logic [31:0] t, w0, w1, w2, w3;
  assign t = {sbox(key_i[23:16]), sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])} ^ {rcon_i, 24'h0};
  assign w0 = key_i[127:96] ^ t;
  assign w1 = key_i[95:64] ^ w0;
  assign w2 = key_i[63:32] ^ w1;
  assign w3 = key_i[31:0] ^ w2;
  assign key_o = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption, one round per clock, on-the-fly key expansion
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [3:0] NR_L = 4'(NR);
  aes_state_e state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, rk_n, sr;
  logic last;
  aes_key_step u_ks (.key_i(rk_q), .rcon_i(rcon(rnd_q)), .key_o(rk_n));
  assign sr = shift_rows(sub_bytes(st_q));
  assign last = rnd_q == NR_L;
  // rnd parks at NR through DONE so it never exceeds NR
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    st_d = st_q;
    rk_d = rk_q;
    if (state_q == IDLE && in_valid) begin
      st_d = add_round_key(in_data, in_key);
      rk_d = in_key;
      rnd_d = 4'd1;
      state_d = RUN;
    end else if (state_q == RUN) begin
      st_d = add_round_key(last ? sr : mix_columns(sr), rk_n);
      rk_d = rk_n;
      rnd_d = last ? rnd_q : rnd_q + 4'd1;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      rnd_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q <= '0;
      st_q <= '0;
      rk_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      st_q <= st_d;
      rk_q <= rk_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_data = st_q;
endmodule
